// File: rtl/watch_pkg.sv
// Shared definitions for the watch control unit and datapath: field select
// encodings, per-field limits and widths, and the modulo step helper.
package watch_pkg;

    typedef enum logic [1:0] {
        TIME_MSEC = 2'd0,
        TIME_SEC  = 2'd1,
        TIME_MIN  = 2'd2,
        TIME_HOUR = 2'd3
    } time_sel_e;

    localparam int unsigned MSEC_W = 7;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned HOUR_W = 5;

    // Limits are held at the widest field width so one helper serves all fields.
    localparam logic [6:0] MSEC_MAX = 7'd99;
    localparam logic [6:0] SEC_MAX  = 7'd59;
    localparam logic [6:0] MIN_MAX  = 7'd59;
    localparam logic [6:0] HOUR_MAX = 7'd23;

    function automatic logic [6:0] wrap_step(input logic [6:0] val, input logic [6:0] max,
                                             input logic inc);
        logic [6:0] res;
        if (inc) begin
            res = (val == max) ? 7'd0 : val + 7'd1;
        end else begin
            res = (val == 7'd0) ? max : val - 7'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/watch_tick_gen.sv
// Time-base prescaler: counts 0..DIV-1 while run is high and emits a registered
// one-cycle tick after the terminal count. Shared with the stopwatch datapath.
module watch_tick_gen #(
    parameter int unsigned DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             at_last;

    assign at_last = run && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= at_last;
            if (run) begin
                cnt_q <= at_last ? '0 : cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/watch_dp.sv
// Watch datapath: 24-hour hh:mm:ss:cc counter advanced by a divided tick, with
// single-step button adjust of the selected field. Optional auto-repeat on held
// buttons is enabled by defining WATCH_AUTO_REPEAT_EN.
module watch_dp
    import watch_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 100_000_000,
    parameter int unsigned TICK_HZ          = 100,
    parameter int unsigned REPEAT_DELAY_CYC = 50_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 10_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [1:0]        time_select,
    input  logic [1:0]        up_down,
    output logic [MSEC_W-1:0] o_msec,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic              o_tick
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;

    if (DIV < 2 || REPEAT_DELAY_CYC < 1 || REPEAT_RATE_CYC < 1) begin : g_bad_cfg
        $error("watch_dp: CLK_HZ/TICK_HZ must be >= 2 and REPEAT_* must be >= 1");
    end

    watch_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .run (run),
        .tick(o_tick)
    );

    logic up, down;
    logic up_d_q, down_d_q;
    logic up_edge, dn_edge;
    logic step_up, step_dn;

    assign up      = up_down[1];
    assign down    = up_down[0];
    // Any overlap with the other button suppresses the step.
    assign up_edge = up & ~up_d_q & ~down;
    assign dn_edge = down & ~down_d_q & ~up;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_d_q   <= 1'b0;
            down_d_q <= 1'b0;
        end else begin
            up_d_q   <= up;
            down_d_q <= down;
        end
    end

`ifdef WATCH_AUTO_REPEAT_EN
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                       REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    logic [1:0]        sel_d_q;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_target;
    logic              armed_q, armed_d;
    logic              held_up, held_dn, rep;

    assign held_up = up & up_d_q & ~down & (time_select == sel_d_q);
    assign held_dn = down & down_d_q & ~up & (time_select == sel_d_q);
    assign hold_target = armed_q ? HOLD_W'(REPEAT_RATE_CYC - 1) : HOLD_W'(REPEAT_DELAY_CYC - 1);

    // hold_q counts cycles held including the press cycle, minus one.
    always_comb begin
        hold_d  = '0;
        armed_d = 1'b0;
        rep     = 1'b0;
        if (up_edge || dn_edge) begin
            hold_d = HOLD_W'(1);
        end else if (held_up || held_dn) begin
            armed_d = armed_q;
            if (hold_q == hold_target) begin
                rep     = 1'b1;
                hold_d  = '0;
                armed_d = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_d_q <= 2'd0;
            hold_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            sel_d_q <= time_select;
            hold_q  <= hold_d;
            armed_q <= armed_d;
        end
    end

    assign step_up = up_edge | (rep & held_up);
    assign step_dn = dn_edge | (rep & held_dn);
`else
    assign step_up = up_edge;
    assign step_dn = dn_edge;
`endif

    logic [MSEC_W-1:0] msec_q, msec_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic [MIN_W-1:0]  min_q, min_d;
    logic [HOUR_W-1:0] hour_q, hour_d;

    // An adjust owns the cycle: a coincident tick is dropped, not deferred.
    always_comb begin
        msec_d = msec_q;
        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (step_up || step_dn) begin
            unique case (time_sel_e'(time_select))
                TIME_MSEC: msec_d = MSEC_W'(wrap_step(msec_q, MSEC_MAX, step_up));
                TIME_SEC:  sec_d  = SEC_W'(wrap_step(7'(sec_q), SEC_MAX, step_up));
                TIME_MIN:  min_d  = MIN_W'(wrap_step(7'(min_q), MIN_MAX, step_up));
                TIME_HOUR: hour_d = HOUR_W'(wrap_step(7'(hour_q), HOUR_MAX, step_up));
            endcase
        end else if (o_tick) begin
            msec_d = MSEC_W'(wrap_step(msec_q, MSEC_MAX, 1'b1));
            if (msec_q == MSEC_MAX) begin
                sec_d = SEC_W'(wrap_step(7'(sec_q), SEC_MAX, 1'b1));
                if (7'(sec_q) == SEC_MAX) begin
                    min_d = MIN_W'(wrap_step(7'(min_q), MIN_MAX, 1'b1));
                    if (7'(min_q) == MIN_MAX) begin
                        hour_d = HOUR_W'(wrap_step(7'(hour_q), HOUR_MAX, 1'b1));
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msec_q <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            hour_q <= '0;
        end else begin
            msec_q <= msec_d;
            sec_q  <= sec_d;
            min_q  <= min_d;
            hour_q <= hour_d;
        end
    end

    assign o_msec = msec_q;
    assign o_sec  = sec_q;
    assign o_min  = min_q;
    assign o_hour = hour_q;

endmodule

// File: doc/watch_dp.md
Name: watch_dp

Overview:
- Datapath end of the watch control interface.
- Consumes time_select and up_down from the watch control unit, and keeps a running 24-hour clock (hour:min:sec:centisecond).
- Advances time from a divided tick and applies single-step adjustments to the selected field.
- Its field outputs feed the FND display mux.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency in Hz.
- TICK_HZ, 100, time-base rate in Hz; one tick = one msec-field count (10 ms).
- REPEAT_DELAY_CYC, 50_000_000, clk cycles a button must be held before auto-repeat starts. Used only with the optional feature.
- REPEAT_RATE_CYC, 10_000_000, clk cycles between auto-repeat steps. Used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  1 = time advances on ticks; 0 = time frozen, prescaler held.
- time_select  in  2  field to adjust: 0 = msec, 1 = sec, 2 = min, 3 = hour.
- up_down  in  2  {up, down}: raw debounced button levels.
- o_msec  out  7  centiseconds, 0..99.
- o_sec  out  6  seconds, 0..59.
- o_min  out  6  minutes, 0..59.
- o_hour  out  5  hours, 0..23.
- o_tick  out  1  one-cycle pulse on each time-base tick.

Behaviour:
- Reset:
  - All field registers, o_tick, the prescaler and the up_down history register go to 0.
  - Reset is asynchronous and may assert mid-count or mid-hold; all state clears immediately.
- Prescaler:
  - Counts 0..DIV-1, where DIV = CLK_HZ/TICK_HZ. Width is $clog2(DIV).
  - Increments only while run=1; holds its value while run=0.
  - o_tick is registered: it is high for exactly one cycle, the cycle after the prescaler is at DIV-1 with run=1. The prescaler then wraps to 0.
- Time advance on o_tick:
  - msec increments. At 99 it wraps to 0 and carries into sec.
  - sec 59→0 carries into min; min 59→0 carries into hour.
  - hour 23→0, with no further carry.
  - All carries resolve in the same cycle: 23:59:59:99 becomes 00:00:00:00 in one tick.
- Edge detect:
  - up_d/down_d register the previous up_down.
  - up_step = up & ~up_d & ~down. dn_step = down & ~down_d & ~up.
  - Both buttons rising together, or one rising while the other is held, produce no step.
- Adjust:
  - up_step increments the selected field modulo its range. dn_step decrements it modulo its range: 0→99, 0→59, 0→59, 0→23.
  - An adjust never carries into or borrows from another field. Example: sec 59 + up → 0, min unchanged.
  - Adjust is allowed regardless of run.
  - Latency: a rising edge sampled at edge N appears on the outputs after edge N+1 (one register stage).
- Simultaneous adjust and tick:
  - The adjust has priority.
  - All fields ignore that tick (no advance, no carries); o_tick still pulses.
- time_select changing while a button is held: causes no step (no new edge).

Optional Feature:
- Macro: WATCH_AUTO_REPEAT_EN.
- Defined:
  - A hold counter starts on a qualified step and counts while the same single button stays high.
  - After REPEAT_DELAY_CYC cycles it generates an extra step, then one step every REPEAT_RATE_CYC cycles while still held.
  - Release, pressing the other button, or a time_select change resets the hold counter.
  - Repeat steps follow the same modulo and priority rules as single steps.
- Not defined: holding a button yields exactly one step. No hold counter is synthesized and the REPEAT_* parameters are ignored.

Decomposition:
- Shared package watch_pkg:
  - Field encodings TIME_MSEC=0, TIME_SEC=1, TIME_MIN=2, TIME_HOUR=3 (shared with the control unit).
  - Limits MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field widths.
- Sub-module watch_tick_gen (prescaler plus o_tick) is natural and reusable by the stopwatch.
- Field counters and adjust logic stay in watch_dp.

Test Plan:
All tests use CLK_HZ=1000 and TICK_HZ=100 (DIV=10), with REPEAT_DELAY_CYC=20 and REPEAT_RATE_CYC=5.
- Rollover: preset to 23:59:59:98 via adjusts, run=1 for 20 cycles → two ticks, outputs 00:00:00:00, o_tick pulsed twice.
- Run gating: run=0 for 100 cycles → no o_tick, fields frozen. run=1 → first o_tick after exactly 10 counting cycles from the held prescaler value.
- Adjust wrap, no carry: select=1, sec=0, pulse down → sec=59, min unchanged. select=3, hour=23, pulse up → hour=0.
- Simultaneous buttons: up and down rise in the same cycle → no change. Hold up, then press down → no step.
- Adjust-tick collision: align an up edge with the o_tick cycle (select=2, msec=5) → min+1, msec stays 5 that tick, o_tick=1.
- Auto-repeat (with WATCH_AUTO_REPEAT_EN): hold up 40 cycles on min=0 → min=1+1+4=6. Without the macro → min=1.
